matvec_stream_mac: RTL and testbench
====================================

Name: matvec_stream_mac

Overview:
- Parametrised streaming signed matrix-vector multiplier: y = W·x, where W is K×K and x is K elements.
- One ready/valid input stream loads W (optional, row-major) followed by x; results leave on a ready/valid output stream.
- K parallel MACs consume one column per cycle, with saturating or wrapping accumulation.
- Results pass through an internal output FIFO, so loading the next vector overlaps with draining the previous results.

Parameters:
- K, 8, matrix dimension and MAC count (≥2).
- IW, 14, signed input element width.
- OW, 2*IW, signed accumulator/output width (≥2*IW).
- FDEPTH, K, output FIFO depth (≥2).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- input_valid  in  1  input element valid.
- input_ready  out  1  block accepts input element.
- input_data  in  IW  signed element (W row-major, then x).
- new_matrix  in  1  sampled with the first element of a transaction: 1 = K*K W elements precede x.
- output_valid  out  1  output_data holds a result.
- output_ready  in  1  consumer accepts result.
- output_data  out  OW  signed result y[i], emitted in order i=0..K-1.

Behaviour:
- Interface: one clock domain, clk; reset is synchronous and active-low.
- Reset (reset==0 at a clk edge):
  - state←IDLE; all counters, accumulators and FIFO pointers←0.
  - Outputs: input_ready=0, output_valid=0, output_data=0.
  - W/x storage is not cleared.
  - Reset mid-transfer discards the partial load and all queued results.
- Input transfer occurs on input_valid&&input_ready.
- States:
  - IDLE: input_ready=1.
    - First transfer with new_matrix=1: store as W[0][0] and go to LOAD_W.
    - First transfer with new_matrix=0: store as x[0] and go to LOAD_X (stored W reused).
  - LOAD_W: input_ready=1; accepts W elements up to index K*K-1, then goes to LOAD_X.
  - LOAD_X: input_ready=1; accepts x up to index K-1, then goes to COMPUTE.
  - COMPUTE: K cycles, input_ready=0.
    - Cycle c: acc[i] ← f(acc[i] + W[i][c]*x[c]) for all i in parallel.
    - Accumulators are cleared on entry.
  - PUSH: input_ready=0.
    - Writes acc[j] into the FIFO, one per cycle, j=0..K-1.
    - Stalls while the FIFO is full; it does not drop data.
    - After the last push, goes to IDLE.
- new_matrix is ignored except on the first transfer of a transaction.
- Arithmetic:
  - Product is the full 2*IW signed product, sign-extended to OW.
  - Sum is OW-bit; f() per the Optional Feature.
- Output FIFO: show-ahead.
  - A result pushed at edge n is visible with output_valid=1 after edge n.
  - Output transfer occurs on output_valid&&output_ready.
  - Simultaneous push and pop when full is allowed; pointers wrap modulo FDEPTH.
  - output_data holds stable while output_valid=1 and output_ready=0.
- Latency (FIFO empty): last x transfer at edge t → y[0] valid after edge t+K+1; y[i] after edge t+K+1+i.
- W loaded with new_matrix=0 before any matrix has ever been loaded: results are undefined (not checked).

Optional Feature:
- Macro: MATVEC_SAT_EN.
- Defined: the signed overflow check is applied on every MAC cycle.
  - Positive addends giving a negative sum yield 2^(OW-1)-1.
  - Negative addends giving a non-negative sum yield -2^(OW-1).
- Undefined: f() is plain two's-complement wraparound modulo 2^OW.

Decomposition:
- Package matvec_pkg:
  - state enum typedef {IDLE, LOAD_W, LOAD_X, COMPUTE, PUSH}.
  - Default parameter constants.
  - Saturating-add function parametrised by width argument.
- Sub-module: matvec_out_fifo (WIDTH, DEPTH).
  - Show-ahead ring buffer with push/full, pop/valid and count.

Test Plan:
- K=4, IW=8, new_matrix=1, W=identity, x=1,2,3,4, output_ready=1 → outputs 1,2,3,4; first output_valid exactly K+1 edges after the last x transfer.
- Same W retained; new_matrix=0, x=-1,5,-7,2 → -1,5,-7,2. Then new_matrix=1, W=all 2, x=1,1,1,1 → 8,8,8,8.
- K=8, IW=14, W=all 8191, x=all 8191:
  - With MATVEC_SAT_EN → eight outputs of 134217727.
  - Without → eight outputs of -131064.
  - Repeat with x=all -8192, W=all 8191 and MATVEC_SAT_EN → -134217728 each.
- Backpressure: output_ready=0 for 30 cycles during two back-to-back vectors (FDEPTH=K).
  - PUSH of vector 2 stalls; output_data stays y0 of vector 1.
  - Releasing output_ready yields all 2K results in order, no loss or duplication.
- Input gaps: input_valid toggled randomly during LOAD_W/LOAD_X → results identical to the gap-free run; input_ready=0 throughout COMPUTE/PUSH.
- Reset (reset=0 for 1 cycle) midway through LOAD_W and again with 3 results queued:
  - Next cycle output_valid=0, input_ready=0, state IDLE.
  - A subsequent full transaction produces correct results.

Source files
------------

// File: rtl/matvec_pkg.sv
// Shared types, default sizes and the width-generic saturating adder for matvec_stream_mac.
package matvec_pkg;

  localparam int unsigned DefK      = 8;
  localparam int unsigned DefIW     = 14;
  localparam int unsigned DefOW     = 2 * DefIW;
  localparam int unsigned DefFDepth = DefK;
  localparam int unsigned SatMaxW   = 64;

  typedef enum logic [2:0] {IDLE, LOAD_W, LOAD_X, COMPUTE, PUSH} state_e;

  // Operands must already be sign-extended values that fit in w bits (w <= 63).
  function automatic logic signed [SatMaxW-1:0] sat_add(input logic signed [SatMaxW-1:0] a,
                                                        input logic signed [SatMaxW-1:0] b,
                                                        input int unsigned w);
    logic signed [SatMaxW-1:0] sum, hi, lo;
    sum = a + b;
    hi  = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo  = ~hi;
    if (sum > hi) begin
      return hi;
    end else if (sum < lo) begin
      return lo;
    end
    return sum;
  endfunction

endpackage

// File: rtl/matvec_stream_mac_if.sv
// Input element stream and result stream of matvec_stream_mac, with both ends as modports.
interface matvec_stream_mac_if #(
  parameter int unsigned IW = 14,
  parameter int unsigned OW = 28
);
  logic                 input_valid;
  logic                 input_ready;
  logic signed [IW-1:0] input_data;
  logic                 new_matrix;
  logic                 output_valid;
  logic                 output_ready;
  logic signed [OW-1:0] output_data;

  modport slave (
    input  input_valid, input_data, new_matrix, output_ready,
    output input_ready, output_valid, output_data
  );

  modport master (
    output input_valid, input_data, new_matrix, output_ready,
    input  input_ready, output_valid, output_data
  );
endinterface

// File: rtl/matvec_out_fifo.sv
// Show-ahead ring-buffer result FIFO; a push into a full FIFO is taken only alongside a pop.
module matvec_out_fifo #(
  parameter int unsigned WIDTH = 28,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_full,
  input  logic             i_pop,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic [CntW-1:0]  o_count
);
  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wptr, r_rptr;
  logic [CntW-1:0]  r_count;
  logic             w_wr, w_rd;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign o_full  = (r_count == CntW'(DEPTH));
  assign o_valid = (r_count != '0);
  assign o_count = r_count;
  assign w_rd    = i_pop && o_valid;
  assign w_wr    = i_push && (!o_full || w_rd);
  // Zero when empty so the output bus is clean straight out of reset.
  assign o_data  = o_valid ? r_mem[r_rptr] : '0;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr) begin
        r_mem[r_wptr] <= i_data;
        r_wptr        <= ptr_inc(r_wptr);
      end
      if (w_rd) begin
        r_rptr <= ptr_inc(r_rptr);
      end
      r_count <= r_count + CntW'(w_wr) - CntW'(w_rd);
    end
  end
endmodule

// File: rtl/matvec_stream_mac.sv
// Streaming signed y = W*x with K parallel MACs and an output FIFO.
// Define MATVEC_SAT_EN for saturating accumulation; otherwise accumulation wraps.
module matvec_stream_mac
  import matvec_pkg::*;
#(
  parameter int unsigned K      = DefK,
  parameter int unsigned IW     = DefIW,
  parameter int unsigned OW     = 2 * IW,
  parameter int unsigned FDEPTH = K
) (
  input logic                clk,
  input logic                reset,
  matvec_stream_mac_if.slave bus
);
  localparam int unsigned CW   = $clog2(K * K);
  localparam int unsigned XW   = $clog2(K);
  localparam int unsigned PW   = 2 * IW;
  localparam int unsigned CntW = $clog2(FDEPTH + 1);

  state_e               r_state, w_state_d;
  logic [CW-1:0]        r_cnt;
  logic                 r_in_rdy;
  logic signed [IW-1:0] r_w   [K*K];
  logic signed [IW-1:0] r_x   [K];
  logic signed [OW-1:0] r_acc [K];
  logic signed [PW-1:0] w_prod  [K];
  logic signed [OW-1:0] w_acc_d [K];
  logic [XW-1:0]        w_col;
  logic                 w_in_xfer, w_load_w, w_last_w, w_last_k;
  logic                 w_push, w_full, w_pop;
  logic [CntW-1:0]      w_count;

  assign w_col           = r_cnt[XW-1:0];
  assign w_in_xfer       = bus.input_valid && r_in_rdy;
  assign w_load_w        = (r_state == LOAD_W) || ((r_state == IDLE) && bus.new_matrix);
  assign w_last_w        = (r_cnt == CW'(K * K - 1));
  assign w_last_k        = (r_cnt == CW'(K - 1));
  assign w_pop           = bus.output_valid && bus.output_ready;
  assign w_push          = (r_state == PUSH) && (!w_full || w_pop);
  assign bus.input_ready = r_in_rdy;

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      IDLE:    if (w_in_xfer) w_state_d = bus.new_matrix ? LOAD_W : LOAD_X;
      LOAD_W:  if (w_in_xfer && w_last_w) w_state_d = LOAD_X;
      LOAD_X:  if (w_in_xfer && w_last_k) w_state_d = COMPUTE;
      COMPUTE: if (w_last_k) w_state_d = PUSH;
      PUSH:    if (w_push && w_last_k) w_state_d = IDLE;
      default: w_state_d = IDLE;
    endcase
  end

  // Ready is registered, so it stays low for one cycle after reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_in_rdy <= 1'b0;
    end else begin
      r_state  <= w_state_d;
      r_in_rdy <= (w_state_d == IDLE) || (w_state_d == LOAD_W) || (w_state_d == LOAD_X);
    end
  end

  // One counter serves as W index, x index, column and push index.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (r_state != w_state_d) begin
      r_cnt <= (r_state == IDLE) ? CW'(1) : '0;
    end else if (w_in_xfer || (r_state == COMPUTE) || w_push) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset && w_in_xfer) begin
      if (w_load_w) r_w[r_cnt] <= bus.input_data;
      else          r_x[w_col] <= bus.input_data;
    end
  end

  always_comb begin
    for (int i = 0; i < K; i++) begin
      w_prod[i] = PW'(r_w[CW'(i * K) + CW'(w_col)]) * PW'(r_x[w_col]);
`ifdef MATVEC_SAT_EN
      w_acc_d[i] = OW'(sat_add(SatMaxW'(r_acc[i]), SatMaxW'(w_prod[i]), OW));
`else
      w_acc_d[i] = r_acc[i] + OW'(w_prod[i]);
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!reset || ((r_state == LOAD_X) && w_in_xfer && w_last_k)) begin
      for (int i = 0; i < K; i++) r_acc[i] <= '0;
    end else if (r_state == COMPUTE) begin
      for (int i = 0; i < K; i++) r_acc[i] <= w_acc_d[i];
    end
  end

  matvec_out_fifo #(
    .WIDTH(OW),
    .DEPTH(FDEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_data  (r_acc[w_col]),
    .o_full  (w_full),
    .i_pop   (bus.output_ready),
    .o_valid (bus.output_valid),
    .o_data  (bus.output_data),
    .o_count (w_count)
  );

  a_count_bound: assert property (@(posedge clk) disable iff (!reset)
                                  w_count <= CntW'(FDEPTH));
endmodule

// File: tb/tb_matvec_stream_mac.sv
// Randomised bench for matvec_stream_mac against a plain-arithmetic model of y = W*x.
module tb_matvec_stream_mac;
  localparam int unsigned K  = 8;
  localparam int unsigned IW = 14;
  localparam int unsigned OW = 2 * IW;
  localparam longint MaxV = (64'sd1 <<< (OW - 1)) - 1;
  localparam longint MinV = -(64'sd1 <<< (OW - 1));

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  matvec_stream_mac_if #(.IW(IW), .OW(OW)) bus ();

  matvec_stream_mac #(.K(K), .IW(IW), .OW(OW), .FDEPTH(K)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad = 0;
  longint exp_q[$];
  longint last_y [K];
  logic signed [IW-1:0] wv [K*K];
  logic signed [IW-1:0] xv [K];
  logic signed [IW-1:0] wm [K*K];
  bit rdy_rand = 0, rdy_force = 0, chk_en = 0, gaps = 0, lat_armed = 0;
  longint t_last = 0;
  bit prev_stall = 0;
  longint prev_data = 0;

  task automatic chk(input string name, input longint got, input longint want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d at t=%0t", name, got, want, $time);
    end
  endtask

  function automatic longint mac_step(input longint acc, input longint p);
    longint s, m;
    s = acc + p;
`ifdef MATVEC_SAT_EN
    if (s > MaxV) s = MaxV;
    if (s < MinV) s = MinV;
`else
    m = 64'sd1 <<< OW;
    s = s & (m - 1);
    if (s >= (m >>> 1)) s = s - m;
`endif
    return s;
  endfunction

  // Result checker and output_ready driver.
  always @(negedge clk) begin
    bus.output_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_force;
    if (chk_en && reset) begin
      if (prev_stall) begin
        chk("hold_valid", longint'(bus.output_valid), 1);
        chk("hold_data", longint'(bus.output_data), prev_data);
      end
      if (bus.output_valid && lat_armed) begin
        chk("latency", ($time - t_last - 5) / 10, K + 1);
        lat_armed = 0;
      end
      if (bus.output_valid && bus.output_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL extra_output got=%0d want=none", bus.output_data);
        end else begin
          chk("y", longint'(bus.output_data), exp_q.pop_front());
        end
      end
      prev_stall = bus.output_valid && !bus.output_ready;
      prev_data  = longint'(bus.output_data);
    end else begin
      prev_stall = 0;
    end
  end

  // Entered and left at a negedge.
  task automatic xfer(input logic signed [IW-1:0] d, input bit nm);
    int g;
    if (gaps) begin
      while ($urandom_range(0, 2) == 0) begin
        bus.input_valid = 1'b0;
        bus.input_data  = IW'($urandom);
        bus.new_matrix  = 1'($urandom);
        @(negedge clk);
      end
    end
    bus.input_valid = 1'b1;
    bus.input_data  = d;
    bus.new_matrix  = nm;
    g = 0;
    while (!bus.input_ready && g < 5000) begin
      @(negedge clk);
      g++;
    end
    if (g >= 5000) begin
      $display("FAIL input_ready_timeout got=0 want=1");
      bad++;
      total++;
    end
    @(posedge clk);
    t_last = $time;
    @(negedge clk);
    bus.input_valid = 1'b0;
    bus.new_matrix  = 1'($urandom);
  endtask

  task automatic send_vec(input bit nm, input int post);
    longint acc;
    if (nm) for (int e = 0; e < K * K; e++) wm[e] = wv[e];
    for (int i = 0; i < K; i++) begin
      acc = 0;
      for (int c = 0; c < K; c++) acc = mac_step(acc, longint'(wm[i*K+c]) * longint'(xv[c]));
      last_y[i] = acc;
      exp_q.push_back(acc);
    end
    if (nm) for (int e = 0; e < K * K; e++) xfer(wv[e], e == 0);
    for (int c = 0; c < K; c++) xfer(xv[c], (c == 0) ? 1'b0 : 1'($urandom));
    for (int p = 0; p < post; p++) begin
      if (p > 0) @(negedge clk);
      chk("busy_ready", longint'(bus.input_ready), 0);
    end
  endtask

  task automatic drain();
    int g = 0;
    while ((exp_q.size() != 0 || bus.output_valid) && g < 5000) begin
      @(negedge clk);
      g++;
    end
    if (g >= 5000) begin
      $display("FAIL drain_timeout got=%0d want=0", exp_q.size());
      bad++;
      total++;
    end
  endtask

  task automatic do_reset();
    chk_en = 0;
    reset = 1'b0;
    exp_q.delete();
    @(posedge clk);
    #1;
    chk("rst_out_valid", longint'(bus.output_valid), 0);
    chk("rst_in_ready", longint'(bus.input_ready), 0);
    chk("rst_out_data", longint'(bus.output_data), 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("idle_in_ready", longint'(bus.input_ready), 1);
    chk_en = 1;
  endtask

  task automatic rand_w(input int mode);
    for (int e = 0; e < K * K; e++)
      wv[e] = (mode == 0) ? IW'($urandom) : IW'($signed($urandom_range(0, 64)) - 32);
  endtask

  task automatic rand_x(input int mode);
    for (int c = 0; c < K; c++)
      xv[c] = (mode == 0) ? IW'($urandom) : IW'($signed($urandom_range(0, 64)) - 32);
  endtask

  initial begin
    logic signed [IW-1:0] x2 [K];
    x2 = '{-1, 5, -7, 2, 3, -4, 100, -8191};
    bus.input_valid  = 1'b0;
    bus.input_data   = '0;
    bus.new_matrix   = 1'b0;
    bus.output_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("init_out_valid", longint'(bus.output_valid), 0);
    chk("init_in_ready", longint'(bus.input_ready), 0);
    chk("init_out_data", longint'(bus.output_data), 0);
    reset = 1'b1;
    @(negedge clk);
    chk_en = 1;
    rdy_force = 1;

    // Identity matrix, first-output latency.
    for (int e = 0; e < K * K; e++) wv[e] = ((e / K) == (e % K)) ? IW'(1) : IW'(0);
    for (int c = 0; c < K; c++) xv[c] = IW'(c + 1);
    lat_armed = 1;
    send_vec(1, 2 * K);
    drain();
    for (int i = 0; i < K; i++) chk("pin_identity", last_y[i], i + 1);

    // Stored W reused.
    for (int c = 0; c < K; c++) xv[c] = x2[c];
    send_vec(0, 2 * K);
    drain();
    for (int i = 0; i < K; i++) chk("pin_reuse", last_y[i], longint'(x2[i]));

    for (int e = 0; e < K * K; e++) wv[e] = 2;
    for (int c = 0; c < K; c++) xv[c] = 1;
    send_vec(1, 2 * K);
    drain();
    chk("pin_all2", last_y[0], 16);

    // Overflow corners.
    for (int e = 0; e < K * K; e++) wv[e] = 8191;
    for (int c = 0; c < K; c++) xv[c] = 8191;
    send_vec(1, 2 * K);
    drain();
`ifdef MATVEC_SAT_EN
    chk("pin_pos_ovf", last_y[K-1], 134217727);
`else
    chk("pin_pos_ovf", last_y[K-1], -131064);
`endif
    for (int c = 0; c < K; c++) xv[c] = -8192;
    send_vec(0, 2 * K);
    drain();
`ifdef MATVEC_SAT_EN
    chk("pin_neg_ovf", last_y[0], -134217728);
`else
    chk("pin_neg_ovf", last_y[0], 65536);
`endif

    // Backpressure across two back-to-back vectors.
    rdy_force = 0;
    rand_w(1);
    rand_x(1);
    send_vec(1, 2 * K);
    rand_x(0);
    send_vec(0, 2 * K);
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      chk("bp_valid", longint'(bus.output_valid), 1);
      chk("bp_head", longint'(bus.output_data), exp_q[0]);
      chk("bp_in_ready", longint'(bus.input_ready), 0);
    end
    rdy_force = 1;
    drain();

    // Random traffic with input gaps and random output_ready.
    gaps = 1;
    rdy_rand = 1;
    for (int v = 0; v < 6; v++) begin
      rand_w(v % 2);
      rand_x($urandom_range(0, 1));
      send_vec((v == 0) || ($urandom_range(0, 1) == 1), 2 * K);
    end
    drain();
    gaps = 0;
    rdy_rand = 0;

    // Reset midway through LOAD_W.
    rdy_force = 0;
    rand_w(0);
    for (int e = 0; e < 10; e++) xfer(wv[e], e == 0);
    do_reset();
    rand_w(0);
    rand_x(0);
    send_vec(1, 2 * K);
    rdy_force = 1;
    drain();

    // Reset with three results queued; W storage survives.
    rdy_force = 0;
    rand_x(0);
    send_vec(0, K + 4);
    chk("q3_valid", longint'(bus.output_valid), 1);
    chk("q3_head", longint'(bus.output_data), exp_q[0]);
    do_reset();
    rand_x(1);
    send_vec(0, 2 * K);
    rdy_force = 1;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end
endmodule
